// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: data width, reset/bubble constants, the fetch FSM
// state encoding and the IF/ID bundle used by both the fetch and decode stages.
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] RESET_PC  = 16'h0000;
  localparam logic [DATA_W-1:0] NOP_INSTR = 16'hB800;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc1;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, write loads a fetched word,
// otherwise the contents hold. Nothing changes unless enable is high.
module if_id_reg #(
  parameter int                DATA_W    = pipe_pkg::DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              write,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc1_in,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc1
);

  logic              valid_reg;
  logic [DATA_W-1:0] instr_reg;
  logic [DATA_W-1:0] pc1_reg;

  // Flush outranks write so a squashed slot never captures the wrong-path word.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= 1'b0;
      instr_reg <= NOP_INSTR;
      pc1_reg   <= '0;
    end else if (enable) begin
      if (flush) begin
        valid_reg <= 1'b0;
        instr_reg <= NOP_INSTR;
        pc1_reg   <= '0;
      end else if (write) begin
        valid_reg <= 1'b1;
        instr_reg <= instr_in;
        pc1_reg   <= pc1_in;
      end
    end
  end

  assign valid = valid_reg;
  assign instr = instr_reg;
  assign pc1   = pc1_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, run/idle/halted FSM and the IF/ID register.
// Define FETCH_COUNT_EN to add a saturating 32-bit count of real fetches (fetch_count).
module fetch_stage #(
  parameter int                DATA_W    = pipe_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [DATA_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              if_id_flush,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              state,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc1
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  import pipe_pkg::*;

  fsm_state_t        fsm_reg, fsm_next;
  logic [DATA_W-1:0] pc_reg, pc_next, pc_plus1;
  logic              advance;

  always_ff @(posedge clock) begin
    if (reset) fsm_reg <= IDLE;
    else       fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE:    if (start)    fsm_next = RUN;
      RUN:     if (halt_req) fsm_next = HALTED;
      HALTED:  if (start)    fsm_next = RUN;
      default: fsm_next = IDLE;
    endcase
  end

  // A halt request freezes the pipeline on the same edge it leaves RUN.
  always_comb begin
    state   = 1'b0;
    advance = 1'b0;
    if (fsm_reg == RUN) begin
      state   = 1'b1;
      advance = ~halt_req;
    end
  end

  assign pc_plus1 = pc_reg + DATA_W'(1);

  always_comb begin
    pc_next = pc_reg;
    if (advance && pc_write) pc_next = branch_taken ? branch_target : pc_plus1;
  end

  always_ff @(posedge clock) begin
    if (reset) pc_reg <= RESET_PC;
    else       pc_reg <= pc_next;
  end

  assign imem_addr = pc_reg;

  if_id_reg #(
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clock    (clock),
    .reset    (reset),
    .enable   (advance),
    .flush    (if_id_flush),
    .write    (if_id_write),
    .instr_in (imem_rdata),
    .pc1_in   (pc_plus1),
    .valid    (if_id_valid),
    .instr    (if_id_instr),
    .pc1      (if_id_pc1)
  );

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_reg;
  logic        fetch_load;

  assign fetch_load = advance & ~if_id_flush & if_id_write;

  always_ff @(posedge clock) begin
    if (reset)
      fetch_count_reg <= '0;
    else if (fetch_load && (fetch_count_reg != 32'hFFFF_FFFF))
      fetch_count_reg <= fetch_count_reg + 32'd1;
  end

  assign fetch_count = fetch_count_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, a fetch-count
// sequence and randomized stimulus against a behavioural reference model.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'hB800;

  logic        clock = 1'b0;
  logic        reset, start, halt_req, pc_write, if_id_write, if_id_flush, branch_taken;
  logic [15:0] branch_target, imem_addr, imem_rdata, if_id_instr, if_id_pc1;
  logic        state, if_id_valid;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: running flag, pc, IF/ID contents, fetch count.
  bit          m_run;
  logic [15:0] m_pc, m_instr, m_pc1;
  bit          m_valid;
  logic [31:0] m_cnt;

  always #5 clock = ~clock;

  assign imem_rdata = 16'h1000 + imem_addr;

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .halt_req      (halt_req),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .state         (state),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc1     (if_id_pc1)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  typedef struct {
    logic        rst, st, hlt, pw, iw, fl, br;
    logic [15:0] tgt;
    logic        e_state;
    logic [15:0] e_pc;
    logic        e_valid;
    logic [15:0] e_instr, e_pc1;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic rst, st, hlt, pw, iw, fl, br,
                              input logic [15:0] tgt, input logic es,
                              input logic [15:0] epc, input logic ev,
                              input logic [15:0] ei, epc1);
    vec_t v;
    v.rst = rst; v.st = st; v.hlt = hlt; v.pw = pw; v.iw = iw; v.fl = fl; v.br = br;
    v.tgt = tgt; v.e_state = es; v.e_pc = epc; v.e_valid = ev; v.e_instr = ei; v.e_pc1 = epc1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, st, hlt, pw, iw, fl, br, input logic [15:0] tgt);
    reset = rst; start = st; halt_req = hlt; pc_write = pw;
    if_id_write = iw; if_id_flush = fl; branch_taken = br; branch_target = tgt;
  endtask

  // Apply the rules of one rising edge to the model.
  task automatic model_edge();
    logic [15:0] old_pc;
    if (reset) begin
      m_run = 0; m_pc = 16'h0000; m_valid = 0; m_instr = NOP; m_pc1 = 16'h0000; m_cnt = 0;
    end else if (!m_run) begin
      if (start) m_run = 1;
    end else if (halt_req) begin
      m_run = 0;
    end else begin
      old_pc = m_pc;
      if (if_id_flush) begin
        m_valid = 0; m_instr = NOP; m_pc1 = 16'h0000;
      end else if (if_id_write) begin
        m_valid = 1; m_instr = 16'h1000 + old_pc; m_pc1 = old_pc + 16'h0001;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
      if (pc_write) m_pc = branch_taken ? branch_target : old_pc + 16'h0001;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic check_count(input string tag);
`ifdef FETCH_COUNT_EN
    chk({tag, ".count"}, fetch_count, m_cnt);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"}, {31'd0, state}, {31'd0, m_run});
    chk({tag, ".pc"}, {16'd0, imem_addr}, {16'd0, m_pc});
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
    chk({tag, ".instr"}, {16'd0, if_id_instr}, {16'd0, m_instr});
    chk({tag, ".pc1"}, {16'd0, if_id_pc1}, {16'd0, m_pc1});
    check_count(tag);
  endtask

  initial begin
    //                 rst st hlt pw iw fl br tgt       | st pc        v  instr     pc1
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, NOP,      16'h0000);
    vecs[1]  = mk(0, 1, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0000, 0, NOP,      16'h0000);
    vecs[2]  = mk(0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0001, 1, 16'h1000, 16'h0001);
    vecs[3]  = mk(0, 1, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h1001, 16'h0002);
    vecs[4]  = mk(0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0003, 1, 16'h1002, 16'h0003);
    vecs[5]  = mk(0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'h1003, 16'h0004);
    vecs[6]  = mk(0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0005, 1, 16'h1004, 16'h0005);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 16'h0077, 1, 16'h0005, 1, 16'h1004, 16'h0005);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0005, 1, 16'h1004, 16'h0005);
    vecs[9]  = mk(0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'h1005, 16'h0006);
    vecs[10] = mk(0, 0, 0, 1, 1, 1, 1, 16'h0040, 1, 16'h0040, 0, NOP,      16'h0000);
    vecs[11] = mk(0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0041, 1, 16'h1040, 16'h0041);
    vecs[12] = mk(0, 0, 0, 1, 1, 1, 1, 16'h0009, 1, 16'h0009, 0, NOP,      16'h0000);
    vecs[13] = mk(0, 0, 1, 1, 1, 0, 0, 16'h0000, 0, 16'h0009, 0, NOP,      16'h0000);
    vecs[14] = mk(0, 0, 0, 1, 1, 0, 1, 16'h0020, 0, 16'h0009, 0, NOP,      16'h0000);
    vecs[15] = mk(0, 1, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0009, 0, NOP,      16'h0000);
    vecs[16] = mk(0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h000A, 1, 16'h1009, 16'h000A);
    vecs[17] = mk(0, 0, 0, 1, 1, 1, 1, 16'hFFFF, 1, 16'hFFFF, 0, NOP,      16'h0000);
    vecs[18] = mk(0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0FFF, 16'h0000);
    vecs[19] = mk(0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0001, 1, 16'h1000, 16'h0001);
    vecs[20] = mk(1, 0, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, NOP,      16'h0000);
    vecs[21] = mk(0, 0, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, NOP,      16'h0000);

    m_run = 0; m_pc = 0; m_valid = 0; m_instr = NOP; m_pc1 = 0; m_cnt = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0000);

    // Directed vector table.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].hlt, vecs[i].pw, vecs[i].iw,
            vecs[i].fl, vecs[i].br, vecs[i].tgt);
      step();
      $display("vec %0d: state=%0d pc=%h valid=%0d instr=%h pc1=%h",
               i, state, imem_addr, if_id_valid, if_id_instr, if_id_pc1);
      chk($sformatf("vec%0d.state", i), {31'd0, state}, {31'd0, vecs[i].e_state});
      chk($sformatf("vec%0d.pc", i), {16'd0, imem_addr}, {16'd0, vecs[i].e_pc});
      chk($sformatf("vec%0d.valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d.instr", i), {16'd0, if_id_instr}, {16'd0, vecs[i].e_instr});
      chk($sformatf("vec%0d.pc1", i), {16'd0, if_id_pc1}, {16'd0, vecs[i].e_pc1});
      check_count($sformatf("vec%0d", i));
    end

    // Fetch count: 3 real fetches, 1 flush, 1 stall.
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0000); step();
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0000); step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 1, 0, 0, 16'h0000); step();
    end
    drive(0, 0, 0, 1, 1, 1, 0, 16'h0000); step();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0000); step();
    $display("count seq: pc=%h valid=%0d", imem_addr, if_id_valid);
    chk("cnt.pc", {16'd0, imem_addr}, 32'h0000_0004);
    chk("cnt.valid", {31'd0, if_id_valid}, 32'd0);
`ifdef FETCH_COUNT_EN
    chk("cnt.fetch_count", fetch_count, 32'd3);
`endif

    // Randomized stimulus against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 50) == 0, ($urandom % 8) == 0, ($urandom % 12) == 0,
            ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 6) == 0,
            ($urandom % 5) == 0, 16'($urandom));
      step();
      $display("rand %0d: rst=%0d st=%0d hlt=%0d pw=%0d iw=%0d fl=%0d br=%0d -> state=%0d pc=%h instr=%h",
               n, reset, start, halt_req, pc_write, if_id_write, if_id_flush, branch_taken,
               state, imem_addr, if_id_instr);
      check_model($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the hazard unit and decode stage.
- Holds the PC, drives the instruction-memory address and latches the fetched word into IF/ID.
- Obeys the hazard unit's pc_write / if_id_write / if_id_flush controls.
- Owns the run/idle/halted state machine whose `state` output gates the hazard unit.

Parameters:
- DATA_W, 16, instruction and address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'hB800, encoding written into IF/ID on flush/reset (bubble).

Ports:
- clock  in  1  single system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse (debounced exec button); begins or resumes execution.
- halt_req  in  1  HLT decoded in ID (op_halt).
- pc_write  in  1  PC update enable from hazard unit.
- if_id_write  in  1  IF/ID load enable from hazard unit.
- if_id_flush  in  1  IF/ID bubble insert from hazard unit.
- branch_taken  in  1  resolved taken branch/jump.
- branch_target  in  DATA_W  target address for branch_taken.
- imem_addr  out  DATA_W  instruction memory address, equals pc (combinational).
- imem_rdata  in  DATA_W  instruction word, combinational-read memory, valid same cycle.
- state  out  1  1 in RUN, 0 in IDLE/HALTED.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  DATA_W  latched instruction.
- if_id_pc1  out  DATA_W  latched PC+1 of that instruction.

Behaviour:
- Reset, on any clock edge with reset=1, overriding all other inputs:
  - FSM goes to IDLE.
  - pc = RESET_PC.
  - if_id_valid = 0, if_id_instr = NOP_INSTR, if_id_pc1 = 0.
  - state = 0.
  - Reset mid-RUN aborts immediately with no partial update.
- FSM states IDLE, RUN, HALTED; 2-bit encoding from the package.
  - IDLE: start → RUN.
  - RUN: halt_req → HALTED, which takes priority over any PC/IF-ID update that edge. Otherwise RUN.
  - HALTED: start → RUN, resuming from the held pc with IF/ID contents held.
  - start while in RUN is ignored.
- state = 1 only in RUN. It is registered and changes one cycle after the start or halt edge.
- PC update (RUN and halt_req=0 only):
  - pc_write=1 and branch_taken=1 → pc = branch_target.
  - pc_write=1 and branch_taken=0 → pc = pc+1, modulo 2^DATA_W (16'hFFFF wraps to 16'h0000).
  - pc_write=0 → hold; branch_taken is ignored.
- IF/ID update (RUN and halt_req=0 only):
  - if_id_flush=1 → valid=0, instr=NOP_INSTR, pc1=0. Flush beats if_id_write when both are asserted.
  - else if_id_write=1 → valid=1, instr=imem_rdata, pc1=pc+1 (pre-update pc, same wrap rule).
  - else hold all three.
- Outside RUN: PC and IF/ID hold regardless of control inputs.
- Latency: an instruction at address A appears on if_id_instr the cycle after pc==A with if_id_write=1.
- imem_addr follows pc with zero latency.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined:
  - Extra output fetch_count, 32 bits.
  - Cleared on reset.
  - Increments on every edge where IF/ID loads a real instruction (RUN, no halt_req, no flush, if_id_write=1).
  - Saturates at 32'hFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W, RESET_PC, NOP_INSTR.
  - FSM state encoding constants (IDLE=2'd0, RUN=2'd1, HALTED=2'd2).
  - The IF/ID bundle typedef {valid, instr, pc1}, reused by the decode stage.
- One natural sub-module, if_id_reg: the flush/write/hold register for the bundle.
- FSM and PC stay in fetch_stage.

Test Plan:
- Reset, then start pulse, with pc_write=if_id_write=1 and imem returning 16'h1000+addr:
  - state=1 one cycle after start.
  - Over consecutive cycles if_id_instr = 1000, 1001, 1002 with if_id_pc1 = 1, 2, 3.
- Stall: in RUN at pc=5, hold pc_write=if_id_write=0 for 2 cycles → pc stays 5 and IF/ID stays unchanged; releasing both resumes at 5→6.
- Branch plus flush together: pc_write=1, branch_taken=1, branch_target=16'h0040, if_id_flush=1, if_id_write=1 → next cycle pc=0x40, if_id_valid=0, if_id_instr=NOP_INSTR.
- Halt then resume:
  - halt_req=1 at pc=9 → HALTED, state=0, pc stays 9 even with pc_write=1.
  - start → RUN, fetch continues from 9.
- Wrap and reset: pc=16'hFFFF with pc_write=1 → pc=0 and if_id_pc1=0. Reset asserted mid-RUN → IDLE, pc=0, if_id_valid=0 next edge.
- FETCH_COUNT_EN: 3 normal fetches, 1 flush, 1 stall → fetch_count=3.
